// File: rtl/ram_word_loader.sv
// Byte-stream loader for the protected RAM: packs bytes little-endian into words,
// writes them to sequential addresses and verifies each write-through readback.
module ram_word_loader #(
  parameter int N         = 64,
  parameter int ADDR_BITS = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 in_valid,
  input  logic [7:0]           in_data,
  output logic                 in_ready,
  output logic [ADDR_BITS-1:0] ram_addr,
  output logic [N-1:0]         ram_data,
  output logic                 ram_wr_en,
  input  logic [N-1:0]         ram_rdata,
  output logic                 busy,
  output logic                 done,
  output logic                 err,
  output logic [ADDR_BITS:0]   word_count
);

  localparam int BYTES     = N / 8;
  localparam int BI_W      = (BYTES > 1) ? $clog2(BYTES) : 1;
  localparam int NUM_WORDS = 1 << ADDR_BITS;

  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] COLLECT = 3'd1;
  localparam logic [2:0] WRITE   = 3'd2;
  localparam logic [2:0] CHECK   = 3'd3;
  localparam logic [2:0] DONE    = 3'd4;

  logic [2:0]           state;
  logic [BI_W-1:0]      byte_idx;
  logic [N-1:0]         word;
  logic [ADDR_BITS-1:0] addr;

  // Every output is a decode of registered state, so in_ready never depends on in_valid.
  assign in_ready  = (state == COLLECT);
  assign ram_wr_en = (state == WRITE);
  assign busy      = (state == COLLECT) || (state == WRITE) || (state == CHECK);
  assign done      = (state == DONE);
  assign ram_addr  = addr;
  assign ram_data  = word;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      byte_idx   <= '0;
      word       <= '0;
      addr       <= '0;
      word_count <= '0;
      err        <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            state      <= COLLECT;
            byte_idx   <= '0;
            addr       <= '0;
            word_count <= '0;
            err        <= 1'b0;
          end
        end
        COLLECT: begin
          if (in_valid) begin
            word[byte_idx*8 +: 8] <= in_data;
            if (byte_idx == BI_W'(BYTES - 1))
              state <= WRITE;
            else
              byte_idx <= byte_idx + 1'b1;
          end
        end
        WRITE: begin
          state <= CHECK;
        end
        CHECK: begin
          // The RAM updates data_out on the write edge, so readback is valid here.
          if (ram_rdata != word)
            err <= 1'b1;
          word_count <= word_count + 1'b1;
          if (addr == ADDR_BITS'(NUM_WORDS - 1)) begin
            state <= DONE;
          end else begin
            addr     <= addr + 1'b1;
            byte_idx <= '0;
            state    <= COLLECT;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ram_word_loader.sv
// Directed bench for ram_word_loader with a write-through RAM model and
// an optional single-bit readback corruption at address 5.
module tb_ram_word_loader;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        in_valid = 1'b0;
  logic [7:0]  in_data = 8'h00;
  logic        in_ready;
  logic [3:0]  ram_addr;
  logic [63:0] ram_data;
  logic        ram_wr_en;
  logic [63:0] ram_rdata;
  logic        busy;
  logic        done;
  logic        err;
  logic [4:0]  word_count;

  ram_word_loader #(.N(64), .ADDR_BITS(4)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .ram_addr(ram_addr), .ram_data(ram_data), .ram_wr_en(ram_wr_en),
    .ram_rdata(ram_rdata), .busy(busy), .done(done), .err(err),
    .word_count(word_count)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [63:0] mem [16];
  logic [63:0] ram_q = '0;
  logic        corrupt = 1'b0;
  int          feed_mode = 0;
  int          wr_cnt = 0;
  int          byte_ptr = 0;
  int          addr_bad = 0;
  int          rdy_bad = 0;
  logic        prev_wr = 1'b0;

  assign ram_rdata = ram_q ^ {63'b0, (corrupt && ram_addr == 4'd5)};

  // RAM model plus handshake/write monitor
  always @(posedge clk) begin
    if (rst_n) begin
      if (start && !busy) begin
        wr_cnt = 0;
        byte_ptr = 0;
        for (int k = 0; k < 16; k++) mem[k] <= '0;
      end else begin
        if (in_valid && in_ready) byte_ptr = byte_ptr + 1;
        if ((prev_wr || ram_wr_en) && in_ready) rdy_bad++;
        if (ram_wr_en) begin
          if (ram_addr != wr_cnt[3:0]) addr_bad++;
          mem[ram_addr] <= ram_data;
          ram_q <= ram_data;
          wr_cnt++;
        end
      end
      prev_wr = ram_wr_en;
    end
  end

  always @(negedge clk) begin
    in_data = byte_ptr[7:0];
    case (feed_mode)
      1:       in_valid = 1'b1;
      2:       in_valid = ($urandom_range(0, 1) == 1);
      default: in_valid = 1'b0;
    endcase
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] exp_word(input int w);
    logic [63:0] v;
    for (int i = 0; i < 8; i++) v[8*i +: 8] = 8'(8*w + i);
    return v;
  endfunction

  function automatic int bad_words();
    int n = 0;
    for (int w = 0; w < 16; w++) if (mem[w] !== exp_word(w)) n++;
    return n;
  endfunction

  task automatic start_load(input int mode);
    feed_mode = mode;
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
  endtask

  task automatic wait_done(output int edges);
    edges = 0;
    while (!done && edges < 3000) begin
      @(negedge clk);
      edges++;
    end
    if (!done) check("done_timeout", 64'd0, 64'd1);
    feed_mode = 0;
  endtask

  task automatic wait_writes(input int n);
    int t = 0;
    while (wr_cnt < n && t < 3000) begin
      @(negedge clk);
      t++;
    end
    if (wr_cnt < n) check("write_timeout", 64'(wr_cnt), 64'(n));
  endtask

  int edges;

  initial begin
    repeat (3) @(negedge clk);
    check("rst_busy", {63'b0, busy}, 64'd0);
    check("rst_ready", {63'b0, in_ready}, 64'd0);
    check("rst_wr_en", {63'b0, ram_wr_en}, 64'd0);
    check("rst_done_err", {62'b0, done, err}, 64'd0);
    check("rst_addr_data", {60'b0, ram_addr} | ram_data, 64'd0);
    check("rst_count", 64'(word_count), 64'd0);
    @(negedge clk) rst_n = 1'b1;
    @(negedge clk);

    // continuous stream
    start_load(1);
    check("busy_after_start", {63'b0, busy}, 64'd1);
    wait_done(edges);
    check("done_latency", 64'(edges), 64'd160);
    check("pulses_cont", 64'(wr_cnt), 64'd16);
    check("word0", mem[0], 64'h0706050403020100);
    check("word15", mem[15], 64'h7F7E7D7C7B7A7978);
    check("words_cont", 64'(bad_words()), 64'd0);
    check("err_cont", {63'b0, err}, 64'd0);
    check("count_cont", 64'(word_count), 64'd16);
    check("busy_at_done", {63'b0, busy}, 64'd0);

    // gappy stream
    start_load(2);
    wait_done(edges);
    check("pulses_rand", 64'(wr_cnt), 64'd16);
    check("words_rand", 64'(bad_words()), 64'd0);
    check("ready_in_wr_chk", 64'(rdy_bad), 64'd0);
    check("err_rand", {63'b0, err}, 64'd0);

    // corrupted readback of word 5
    corrupt = 1'b1;
    start_load(1);
    wait_writes(6);
    check("err_before_chk5", {63'b0, err}, 64'd0);
    @(negedge clk);
    check("err_after_chk5", {63'b0, err}, 64'd1);
    wait_done(edges);
    corrupt = 1'b0;
    check("err_sticky", {63'b0, err}, 64'd1);
    check("done_corrupt", {63'b0, done}, 64'd1);
    check("pulses_corrupt", 64'(wr_cnt), 64'd16);

    // restart after done, with a stray start while busy
    start_load(1);
    check("err_cleared", {63'b0, err}, 64'd0);
    check("done_cleared", {63'b0, done}, 64'd0);
    repeat (37) @(negedge clk);
    start = 1'b1;
    @(negedge clk) start = 1'b0;
    wait_done(edges);
    check("pulses_restart", 64'(wr_cnt), 64'd16);
    check("words_restart", 64'(bad_words()), 64'd0);
    check("addr_seq", 64'(addr_bad), 64'd0);

    // asynchronous reset inside word 2
    start_load(1);
    begin
      int t = 0;
      while (byte_ptr < 19 && t < 3000) begin
        @(negedge clk);
        t++;
      end
      if (byte_ptr < 19) check("byte_timeout", 64'(byte_ptr), 64'd19);
    end
    #2 rst_n = 1'b0;
    feed_mode = 0;
    #1;
    check("arst_busy", {63'b0, busy}, 64'd0);
    check("arst_ready", {63'b0, in_ready}, 64'd0);
    check("arst_addr_data", {60'b0, ram_addr} | ram_data, 64'd0);
    check("arst_count", 64'(word_count), 64'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    check("no_write_after_rst", 64'(wr_cnt), 64'd2);
    check("idle_after_rst", {62'b0, busy, ram_wr_en}, 64'd0);
    start_load(1);
    begin
      int t = 0;
      while (!ram_wr_en && t < 100) begin
        @(negedge clk);
        t++;
      end
    end
    check("reload_wr_en", {63'b0, ram_wr_en}, 64'd1);
    check("reload_addr0", 64'(ram_addr), 64'd0);
    check("reload_count0", 64'(word_count), 64'd0);
    @(negedge clk);
    @(negedge clk);
    check("reload_count1", 64'(word_count), 64'd1);
    wait_done(edges);
    check("reload_count16", 64'(word_count), 64'd16);
    check("reload_words", 64'(bad_words()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
